// File: rtl/cache_port_arbiter_if.sv
// Shared operation type for the cache port, plus the bundled bus between the
// requesting channels, the arbiter and the single downstream cache port.
package cachepkg;
  typedef enum logic [1:0] {
    INST_READ       = 2'd0,
    INST_WRITE      = 2'd1,
    INST_FLUSH      = 2'd2,
    INST_INVALIDATE = 2'd3
  } inst_t;
endpackage

interface cache_port_arbiter_if #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int NUMPORTS     = 4
);
  localparam int ID_W = $clog2(NUMPORTS);

  // Upstream channels, packed with channel i at [i*W +: W]
  logic [NUMPORTS-1:0]              up_request;
  cachepkg::inst_t [NUMPORTS-1:0]   up_operation;
  logic [NUMPORTS*ADDRESSWIDTH-1:0] up_addr;
  logic [NUMPORTS*DATAWIDTH-1:0]    up_wdata;
  logic [NUMPORTS-1:0]              up_valid;
  logic [NUMPORTS-1:0]              up_evict;
  logic [DATAWIDTH-1:0]             up_rdata;

  // Downstream cache port
  logic                             dn_request;
  cachepkg::inst_t                  dn_operation;
  logic [ADDRESSWIDTH-1:0]          dn_addr;
  logic [DATAWIDTH-1:0]             dn_wdata;
  logic                             dn_valid;
  logic                             dn_evict;
  logic [DATAWIDTH-1:0]             dn_rdata;

  // Status
  logic [ID_W-1:0]                  grant_id;
  logic                             busy;

  // Arbiter view
  modport slave (
    input  up_request, up_operation, up_addr, up_wdata,
    input  dn_valid, dn_evict, dn_rdata,
    output up_valid, up_evict, up_rdata,
    output dn_request, dn_operation, dn_addr, dn_wdata,
    output grant_id, busy
  );

  // Environment view: requesters and cache together
  modport master (
    output up_request, up_operation, up_addr, up_wdata,
    output dn_valid, dn_evict, dn_rdata,
    input  up_valid, up_evict, up_rdata,
    input  dn_request, dn_operation, dn_addr, dn_wdata,
    input  grant_id, busy
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter funnelling NUMPORTS 4-phase requesters onto one 4-phase
// cache port. One transaction is in flight at a time; the next grant waits
// until the cache has released dn_valid.
module cache_port_arbiter #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int NUMPORTS     = 4
) (
  input  logic                clock,
  input  logic                reset,
  cache_port_arbiter_if.slave bus
);
  import cachepkg::*;

  localparam int ID_W = $clog2(NUMPORTS);

  typedef enum logic [1:0] {IDLE, DN_REQ, UP_ACK, DRAIN} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic            any_request;

  assign bus.busy = (state != IDLE);

  // Find the first requesting channel at or above rr_ptr, wrapping around.
  always_comb begin : pick_next
    logic [ID_W-1:0] cand;
    int              idx;
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned, which would otherwise infer a latch.
    any_request = 1'b0;
    pick        = rr_ptr;
    cand        = '0;
    idx         = 0;
    for (int k = 0; k < NUMPORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUMPORTS) idx = idx - NUMPORTS;
      cand = ID_W'(idx);
      if (!any_request && bus.up_request[cand]) begin
        any_request = 1'b1;
        pick        = cand;
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, regardless of statement order.
      state            <= IDLE;
      rr_ptr           <= '0;
      bus.grant_id     <= '0;
      bus.dn_request   <= 1'b0;
      bus.dn_operation <= INST_READ;
      bus.dn_addr      <= '0;
      bus.dn_wdata     <= '0;
      bus.up_valid     <= '0;
      bus.up_evict     <= '0;
      bus.up_rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_request) begin
            bus.grant_id     <= pick;
            bus.dn_operation <= bus.up_operation[pick];
            bus.dn_addr      <= bus.up_addr[pick*ADDRESSWIDTH +: ADDRESSWIDTH];
            bus.dn_wdata     <= bus.up_wdata[pick*DATAWIDTH +: DATAWIDTH];
            bus.dn_request   <= 1'b1;
            state            <= DN_REQ;
          end
        end

        DN_REQ: begin
          if (bus.dn_valid) begin
            bus.up_rdata   <= bus.dn_rdata;
            bus.up_valid   <= NUMPORTS'(1) << bus.grant_id;
            bus.up_evict   <= NUMPORTS'(bus.dn_evict) << bus.grant_id;
            bus.dn_request <= 1'b0;
            state          <= UP_ACK;
          end
        end

        UP_ACK: begin
          // A channel that already dropped its request falls through here in one cycle.
          if (!bus.up_request[bus.grant_id]) begin
            bus.up_valid <= '0;
            bus.up_evict <= '0;
            state        <= DRAIN;
          end
        end

        DRAIN: begin
          // Hold off the next grant until the cache has finished its handshake.
          if (!bus.dn_valid) begin
            rr_ptr <= (bus.grant_id == ID_W'(NUMPORTS - 1)) ? '0 : bus.grant_id + 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: reset, single read, round robin,
// wrap, evict, drain hold-off, mid-transaction reset, early request drop.
module tb_cache_port_arbiter;
  import cachepkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int NP = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cache_port_arbiter_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .NUMPORTS(NP)) bus ();

  cache_port_arbiter #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .NUMPORTS(NP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.up_request = '0;
    for (int i = 0; i < NP; i++) bus.up_operation[i] = INST_READ;
    bus.up_addr  = '0;
    bus.up_wdata = '0;
    bus.dn_valid = 1'b0;
    bus.dn_evict = 1'b0;
    bus.dn_rdata = '0;
  endtask

  task automatic set_channel(input int ch, input inst_t op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
    bus.up_operation[ch]       = op;
    bus.up_addr[ch*AW +: AW]   = addr;
    bus.up_wdata[ch*DW +: DW]  = wdata;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    quiet_inputs();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet_inputs();
    tick();
    tick();
    checks++; if (bus.dn_request !== 1'b0) begin errors++; $display("FAIL rst_dn_request got %b exp 0", bus.dn_request); end
    checks++; if (bus.up_valid !== 4'b0000) begin errors++; $display("FAIL rst_up_valid got %b exp 0000", bus.up_valid); end
    checks++; if (bus.up_evict !== 4'b0000) begin errors++; $display("FAIL rst_up_evict got %b exp 0000", bus.up_evict); end
    checks++; if (bus.up_rdata !== 8'h00) begin errors++; $display("FAIL rst_up_rdata got %h exp 00", bus.up_rdata); end
    checks++; if (bus.dn_addr !== 32'h0) begin errors++; $display("FAIL rst_dn_addr got %h exp 0", bus.dn_addr); end
    checks++; if (bus.dn_wdata !== 8'h00) begin errors++; $display("FAIL rst_dn_wdata got %h exp 00", bus.dn_wdata); end
    checks++; if (bus.dn_operation !== INST_READ) begin errors++; $display("FAIL rst_dn_operation got %0d exp 0", bus.dn_operation); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d exp 0", bus.grant_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    reset = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_single_read();
    set_channel(2, INST_READ, 32'h0000_1234, 8'h00);
    bus.up_request = 4'b0100;
    tick();
    checks++; if (bus.dn_request !== 1'b1) begin errors++; $display("FAIL sr_dn_request got %b exp 1", bus.dn_request); end
    checks++; if (bus.dn_addr !== 32'h0000_1234) begin errors++; $display("FAIL sr_dn_addr got %h exp 00001234", bus.dn_addr); end
    checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL sr_grant_id got %0d exp 2", bus.grant_id); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sr_busy got %b exp 1", bus.busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.up_valid !== 4'b0000 || bus.dn_request !== 1'b1) begin errors++; $display("FAIL sr_wait up_valid %b dn_request %b exp 0000 1", bus.up_valid, bus.dn_request); end
    end
    bus.dn_valid = 1'b1;
    bus.dn_rdata = 8'hA5;
    tick();
    checks++; if (bus.up_valid !== 4'b0100) begin errors++; $display("FAIL sr_up_valid got %b exp 0100", bus.up_valid); end
    checks++; if (bus.up_rdata !== 8'hA5) begin errors++; $display("FAIL sr_up_rdata got %h exp a5", bus.up_rdata); end
    checks++; if (bus.up_evict !== 4'b0000) begin errors++; $display("FAIL sr_up_evict got %b exp 0000", bus.up_evict); end
    checks++; if (bus.dn_request !== 1'b0) begin errors++; $display("FAIL sr_dn_drop got %b exp 0", bus.dn_request); end
    bus.dn_valid   = 1'b0;
    bus.up_request = 4'b0000;
    tick();
    checks++; if (bus.up_valid !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL sr_drain up_valid %b busy %b exp 0000 1", bus.up_valid, bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sr_idle busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] req;
    apply_reset();
    for (int ch = 0; ch < NP; ch++) set_channel(ch, INST_READ, 32'h100 + ch, 8'h00);
    req = 4'b1111;
    bus.up_request = req;
    for (int k = 0; k < NP; k++) begin
      tick();
      checks++; if (bus.grant_id !== 2'(k)) begin errors++; $display("FAIL rr_grant got %0d exp %0d", bus.grant_id, k); end
      checks++; if (bus.dn_addr !== 32'h100 + k) begin errors++; $display("FAIL rr_dn_addr got %h exp %h", bus.dn_addr, 32'h100 + k); end
      bus.dn_valid = 1'b1;
      bus.dn_rdata = 8'h10 + 8'(k);
      tick();
      checks++; if (bus.up_valid !== (4'b0001 << k)) begin errors++; $display("FAIL rr_up_valid got %b exp %b", bus.up_valid, 4'b0001 << k); end
      checks++; if (bus.up_rdata !== 8'h10 + 8'(k)) begin errors++; $display("FAIL rr_up_rdata got %h exp %h", bus.up_rdata, 8'h10 + 8'(k)); end
      bus.dn_valid = 1'b0;
      req[k] = 1'b0;
      bus.up_request = req;
      tick();
      checks++; if (bus.up_valid !== 4'b0000) begin errors++; $display("FAIL rr_valid_low got %b exp 0000", bus.up_valid); end
      tick();
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    set_channel(3, INST_READ, 32'h3333, 8'h00);
    set_channel(0, INST_READ, 32'h0010, 8'h00);
    bus.up_request = 4'b1000;
    tick();
    checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL wrap_first got %0d exp 3", bus.grant_id); end
    bus.dn_valid = 1'b1;
    tick();
    bus.dn_valid = 1'b0;
    bus.up_request = 4'b0000;
    tick();
    tick();
    bus.up_request = 4'b1001;
    tick();
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL wrap_grant got %0d exp 0", bus.grant_id); end
    checks++; if (bus.dn_addr !== 32'h0010) begin errors++; $display("FAIL wrap_dn_addr got %h exp 00000010", bus.dn_addr); end
    bus.dn_valid = 1'b1;
    tick();
    checks++; if (bus.up_valid !== 4'b0001) begin errors++; $display("FAIL wrap_up_valid got %b exp 0001", bus.up_valid); end
    bus.dn_valid = 1'b0;
    bus.up_request = 4'b1000;
    tick();
    tick();
    tick();
    checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL wrap_pending got %0d exp 3", bus.grant_id); end
    bus.dn_valid = 1'b1;
    tick();
    bus.dn_valid = 1'b0;
    bus.up_request = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_evict();
    set_channel(1, INST_WRITE, 32'h0000_0BEE, 8'h5C);
    bus.up_request = 4'b0010;
    tick();
    checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL ev_grant got %0d exp 1", bus.grant_id); end
    checks++; if (bus.dn_operation !== INST_WRITE) begin errors++; $display("FAIL ev_dn_operation got %0d exp 1", bus.dn_operation); end
    checks++; if (bus.dn_wdata !== 8'h5C) begin errors++; $display("FAIL ev_dn_wdata got %h exp 5c", bus.dn_wdata); end
    bus.dn_valid = 1'b1;
    bus.dn_evict = 1'b1;
    tick();
    checks++; if (bus.up_evict !== 4'b0010) begin errors++; $display("FAIL ev_up_evict got %b exp 0010", bus.up_evict); end
    bus.dn_valid = 1'b0;
    bus.dn_evict = 1'b0;
    tick();
    checks++; if (bus.up_valid !== 4'b0010 || bus.up_evict !== 4'b0010) begin errors++; $display("FAIL ev_hold up_valid %b up_evict %b exp 0010 0010", bus.up_valid, bus.up_evict); end
    bus.up_request = 4'b0000;
    tick();
    checks++; if (bus.up_valid !== 4'b0000 || bus.up_evict !== 4'b0000) begin errors++; $display("FAIL ev_clear up_valid %b up_evict %b exp 0000 0000", bus.up_valid, bus.up_evict); end
    tick();
  endtask

  task automatic test_drain_hold();
    set_channel(2, INST_READ, 32'h2222, 8'h00);
    set_channel(0, INST_READ, 32'h0A0A, 8'h00);
    bus.up_request = 4'b0100;
    tick();
    checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL dr_grant got %0d exp 2", bus.grant_id); end
    bus.dn_valid = 1'b1;
    tick();
    bus.up_request = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b1 || bus.dn_request !== 1'b0 || bus.up_valid !== 4'b0000) begin errors++; $display("FAIL dr_hold busy %b dn_request %b up_valid %b exp 1 0 0000", bus.busy, bus.dn_request, bus.up_valid); end
    end
    bus.dn_valid = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dr_idle busy got %b exp 0", bus.busy); end
    tick();
    checks++; if (bus.grant_id !== 2'd0 || bus.dn_request !== 1'b1) begin errors++; $display("FAIL dr_next grant %0d dn_request %b exp 0 1", bus.grant_id, bus.dn_request); end
    bus.dn_valid = 1'b1;
    tick();
    bus.dn_valid = 1'b0;
    bus.up_request = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    set_channel(3, INST_WRITE, 32'h3000, 8'hEE);
    set_channel(1, INST_READ, 32'h0B0B, 8'h00);
    set_channel(0, INST_READ, 32'h00A0, 8'h00);
    bus.up_request = 4'b1000;
    tick();
    checks++; if (bus.grant_id !== 2'd3 || bus.dn_request !== 1'b1) begin errors++; $display("FAIL mr_grant grant %0d dn_request %b exp 3 1", bus.grant_id, bus.dn_request); end
    reset = 1'b1;
    #2;
    checks++; if (bus.dn_request !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mr_async dn_request %b busy %b exp 0 0", bus.dn_request, bus.busy); end
    checks++; if (bus.grant_id !== 2'd0 || bus.dn_addr !== 32'h0 || bus.dn_wdata !== 8'h00) begin errors++; $display("FAIL mr_async_regs grant %0d addr %h wdata %h exp 0 0 0", bus.grant_id, bus.dn_addr, bus.dn_wdata); end
    bus.dn_valid = 1'b1;
    tick();
    checks++; if (bus.up_valid !== 4'b0000) begin errors++; $display("FAIL mr_no_valid got %b exp 0000", bus.up_valid); end
    bus.dn_valid   = 1'b0;
    bus.up_request = 4'b0011;
    reset = 1'b0;
    tick();
    checks++; if (bus.grant_id !== 2'd0 || bus.dn_addr !== 32'h00A0) begin errors++; $display("FAIL mr_first_grant grant %0d addr %h exp 0 000000a0", bus.grant_id, bus.dn_addr); end
    checks++; if (bus.up_valid !== 4'b0000) begin errors++; $display("FAIL mr_valid_after got %b exp 0000", bus.up_valid); end
  endtask

  // Continues from test_mid_reset with channel 0 granted and in DN_REQ.
  task automatic test_early_drop();
    bus.up_request = 4'b0010;
    bus.dn_valid   = 1'b1;
    bus.dn_rdata   = 8'h77;
    tick();
    checks++; if (bus.up_valid !== 4'b0001 || bus.up_rdata !== 8'h77) begin errors++; $display("FAIL ed_ack up_valid %b rdata %h exp 0001 77", bus.up_valid, bus.up_rdata); end
    bus.dn_valid = 1'b0;
    tick();
    checks++; if (bus.up_valid !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL ed_one_cycle up_valid %b busy %b exp 0000 1", bus.up_valid, bus.busy); end
    tick();
    tick();
    checks++; if (bus.grant_id !== 2'd1 || bus.dn_addr !== 32'h0B0B) begin errors++; $display("FAIL ed_next grant %0d addr %h exp 1 00000b0b", bus.grant_id, bus.dn_addr); end
    bus.dn_valid = 1'b1;
    tick();
    bus.dn_valid = 1'b0;
    bus.up_request = 4'b0000;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.up_valid !== 4'b0000) begin errors++; $display("FAIL ed_end busy %b up_valid %b exp 0 0000", bus.busy, bus.up_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wrap();
    test_evict();
    test_drain_hold();
    test_mid_reset();
    test_early_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
